// File: rtl/hue_sequencer_if.sv
// Control/status bundle between the hue sequencer and its host/PWM stages.
interface hue_sequencer_if #(
    parameter int PWM_INTERVAL = 1200
) ();
    localparam int DW = $clog2(PWM_INTERVAL);

    logic          en;
    logic          restart;
    logic [DW-1:0] pwm_value_R;
    logic [DW-1:0] pwm_value_G;
    logic [DW-1:0] pwm_value_B;
    logic [2:0]    segment;
    logic          update;

    // Host side: drives control, observes duty values.
    modport master (
        output en, restart,
        input  pwm_value_R, pwm_value_G, pwm_value_B, segment, update
    );

    // Sequencer side.
    modport slave (
        input  en, restart,
        output pwm_value_R, pwm_value_G, pwm_value_B, segment, update
    );
endinterface

// File: rtl/hue_sequencer.sv
// Hue wheel sequencer: ramps one colour channel at a time through six
// segments and presents registered R/G/B duty values with an update strobe.
module hue_sequencer #(
    parameter int PWM_INTERVAL = 1200,
    parameter int STEP_CYCLES  = 12000,
    parameter int DUTY_INC     = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    hue_sequencer_if.slave bus
);
    localparam int DW = $clog2(PWM_INTERVAL);
    localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [DW-1:0] DUTY_MAX = DW'(PWM_INTERVAL - 1);
    localparam logic [DW:0]   INC_W    = (DW + 1)'(DUTY_INC);
    localparam logic [TW-1:0] T_LAST   = TW'(STEP_CYCLES - 1);

    logic [TW-1:0] timer_q, timer_d;
    logic [DW-1:0] ramp_q, ramp_d;
    logic [2:0]    seg_q, seg_d;
    logic [DW-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic          upd_q, upd_d;

    logic          step;
    logic [DW:0]   ramp_sum;
    logic [DW-1:0] duty_r, duty_g, duty_b;

    assign step     = bus.en && (timer_q == T_LAST);
    // One bit wider so a large increment near the top cannot wrap.
    assign ramp_sum = {1'b0, ramp_q} + INC_W;

    // Timer / ramp / segment next state; restart beats a coincident step.
    always_comb begin
        timer_d = timer_q;
        ramp_d  = ramp_q;
        seg_d   = seg_q;
        upd_d   = 1'b0;
        if (bus.restart) begin
            timer_d = '0;
            ramp_d  = '0;
            seg_d   = '0;
            upd_d   = 1'b1;
        end else if (bus.en) begin
            timer_d = step ? '0 : timer_q + TW'(1);
            if (step) begin
                upd_d = 1'b1;
                if (ramp_q == DUTY_MAX) begin
                    ramp_d = '0;
                    seg_d  = (seg_q == 3'd5) ? 3'd0 : seg_q + 3'd1;
                end else if (ramp_sum > {1'b0, DUTY_MAX}) begin
                    ramp_d = DUTY_MAX;
                end else begin
                    ramp_d = ramp_sum[DW-1:0];
                end
            end
        end
    end

    // Duty mapping of the post-step ramp/segment onto the three channels.
    always_comb begin
        duty_r = '0;
        duty_g = '0;
        duty_b = '0;
        case (seg_d)
            3'd0:    begin duty_r = DUTY_MAX;          duty_g = ramp_d;            end
            3'd1:    begin duty_r = DUTY_MAX - ramp_d; duty_g = DUTY_MAX;          end
            3'd2:    begin duty_g = DUTY_MAX;          duty_b = ramp_d;            end
            3'd3:    begin duty_g = DUTY_MAX - ramp_d; duty_b = DUTY_MAX;          end
            3'd4:    begin duty_r = ramp_d;            duty_b = DUTY_MAX;          end
            3'd5:    begin duty_r = DUTY_MAX;          duty_b = DUTY_MAX - ramp_d; end
            default: begin duty_r = DUTY_MAX;                                      end
        endcase
    end

    // Outputs only reload on a step or restart, so they stay frozen otherwise.
    always_comb begin
        r_d = r_q;
        g_d = g_q;
        b_d = b_q;
        if (upd_d) begin
            r_d = duty_r;
            g_d = duty_g;
            b_d = duty_b;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer_q <= '0;
            ramp_q  <= '0;
            seg_q   <= '0;
            r_q     <= DUTY_MAX;
            g_q     <= '0;
            b_q     <= '0;
            upd_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            ramp_q  <= ramp_d;
            seg_q   <= seg_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            upd_q   <= upd_d;
        end
    end

    assign bus.pwm_value_R = r_q;
    assign bus.pwm_value_G = g_q;
    assign bus.pwm_value_B = b_q;
    assign bus.segment     = seg_q;
    assign bus.update      = upd_q;
endmodule

// File: tb/tb_hue_sequencer.sv
// Bench for hue_sequencer: two instances (DUTY_INC 5 and 4) driven in lockstep,
// a behavioural reference model and per-instance scoreboards of update values.
module tb_hue_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hue_sequencer_if #(.PWM_INTERVAL(16)) bus1 ();
    hue_sequencer_if #(.PWM_INTERVAL(16)) bus2 ();

    hue_sequencer #(.PWM_INTERVAL(16), .STEP_CYCLES(4), .DUTY_INC(5)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));
    hue_sequencer #(.PWM_INTERVAL(16), .STEP_CYCLES(4), .DUTY_INC(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2));

    typedef struct {
        int timer; int ramp; int seg; int r; int g; int b; bit upd;
    } mdl_t;

    mdl_t m1, m2;
    logic [14:0] q1[$], q2[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%0h exp=%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic mdl_t mstep(input mdl_t s, input bit rn, input bit e,
                                   input bit rs, input int inc);
        mdl_t n = s;
        n.upd = 0;
        if (!rn || rs) begin
            n.timer = 0; n.ramp = 0; n.seg = 0; n.r = 15; n.g = 0; n.b = 0;
            n.upd = rn;
            return n;
        end
        if (!e) return n;
        if (s.timer != 3) begin
            n.timer = s.timer + 1;
            return n;
        end
        n.timer = 0;
        n.upd   = 1;
        if (s.ramp == 15) begin
            n.ramp = 0;
            n.seg  = (s.seg + 1) % 6;
        end else begin
            n.ramp = (s.ramp + inc > 15) ? 15 : s.ramp + inc;
        end
        case (n.seg)
            0: begin n.r = 15;          n.g = n.ramp;      n.b = 0;           end
            1: begin n.r = 15 - n.ramp; n.g = 15;          n.b = 0;           end
            2: begin n.r = 0;           n.g = 15;          n.b = n.ramp;      end
            3: begin n.r = 0;           n.g = 15 - n.ramp; n.b = 15;          end
            4: begin n.r = n.ramp;      n.g = 0;           n.b = 15;          end
            default: begin n.r = 15;    n.g = 0;           n.b = 15 - n.ramp; end
        endcase
        return n;
    endfunction

    function automatic logic [14:0] mpack(input mdl_t m);
        return {4'(m.r), 4'(m.g), 4'(m.b), 3'(m.seg)};
    endfunction

    // One clock: drive, advance model (pushing expected updates), check at negedge.
    task automatic tick(input bit rn, input bit e, input bit rs);
        logic [14:0] p1, p2;
        rst_n = rn;
        bus1.en = e; bus1.restart = rs;
        bus2.en = e; bus2.restart = rs;
        @(posedge clk);
        m1 = mstep(m1, rn, e, rs, 5);
        m2 = mstep(m2, rn, e, rs, 4);
        if (m1.upd) q1.push_back(mpack(m1));
        if (m2.upd) q2.push_back(mpack(m2));
        @(negedge clk);
        p1 = {bus1.pwm_value_R, bus1.pwm_value_G, bus1.pwm_value_B, bus1.segment};
        p2 = {bus2.pwm_value_R, bus2.pwm_value_G, bus2.pwm_value_B, bus2.segment};
        chk("upd1", 32'(bus1.update), 32'(m1.upd));
        chk("upd2", 32'(bus2.update), 32'(m2.upd));
        chk("out1", 32'(p1), 32'(mpack(m1)));
        chk("out2", 32'(p2), 32'(mpack(m2)));
        if (bus1.update === 1'b1) begin
            if (q1.size() == 0) chk("sb1_empty", 32'd1, 32'd0);
            else chk("sb1", 32'(p1), 32'(q1.pop_front()));
        end
        if (bus2.update === 1'b1) begin
            if (q2.size() == 0) chk("sb2_empty", 32'd1, 32'd0);
            else chk("sb2", 32'(p2), 32'(q2.pop_front()));
        end
    endtask

    task automatic chk_rgb(input string tag, input int r, input int g, input int b,
                           input int seg, input int upd);
        chk({tag, "_R"},   32'(bus1.pwm_value_R), 32'(r));
        chk({tag, "_G"},   32'(bus1.pwm_value_G), 32'(g));
        chk({tag, "_B"},   32'(bus1.pwm_value_B), 32'(b));
        chk({tag, "_seg"}, 32'(bus1.segment),     32'(seg));
        chk({tag, "_upd"}, 32'(bus1.update),      32'(upd));
    endtask

    initial begin
        int n;
        m1 = '{0, 0, 0, 0, 0, 0, 1'b0};
        m2 = m1;

        // Reset values
        tick(0, 0, 0);
        tick(0, 0, 0);
        chk_rgb("rst", 15, 0, 0, 0, 0);

        // Full wheel: 96 cycles, 24 steps back to segment 0
        for (int i = 0; i < 96; i++) begin
            tick(1, 1, 0);
            if (i == 3)  chk_rgb("step1", 15, 5, 0, 0, 1);
            if (i == 7)  chk_rgb("step2", 15, 10, 0, 0, 1);
            if (i == 11) chk_rgb("step3", 15, 15, 0, 0, 1);
            if (i == 15) chk_rgb("step4", 15, 15, 0, 1, 1);
            if (i == 11) chk("inc4_G12", 32'(bus2.pwm_value_G), 32'd12);
            if (i == 15) chk("inc4_G15", 32'(bus2.pwm_value_G), 32'd15);
            if (i == 19) begin
                chk("inc4_seg1", 32'(bus2.segment), 32'd1);
                chk("inc4_R15",  32'(bus2.pwm_value_R), 32'd15);
            end
        end
        chk_rgb("wheel", 15, 0, 0, 0, 1);

        // Freeze mid-ramp at G=10, then resume
        tick(0, 0, 0);
        for (int i = 0; i < 9; i++) tick(1, 1, 0);
        for (int i = 0; i < 10; i++) begin
            tick(1, 0, 0);
            chk("frz_G", 32'(bus1.pwm_value_G), 32'd10);
        end
        n = 0;
        do begin
            tick(1, 1, 0);
            n++;
        end while (bus1.update !== 1'b1 && n < 20);
        chk("resume_lat", 32'(n), 32'd3);
        chk("resume_G", 32'(bus1.pwm_value_G), 32'd15);

        // Restart on a step cycle in segment 3
        n = 0;
        while (!(m1.seg == 3 && m1.timer == 3) && n < 200) begin
            tick(1, 1, 0);
            n++;
        end
        chk("reach_seg3", 32'(n < 200), 32'd1);
        tick(1, 1, 1);
        chk_rgb("rs_seg3", 15, 0, 0, 0, 1);
        tick(1, 0, 0);
        chk("rs_pulse", 32'(bus1.update), 32'd0);
        tick(1, 0, 1);
        chk_rgb("rs_noen", 15, 0, 0, 0, 1);

        // Reset mid segment 4 with a coincident restart
        n = 0;
        while (!(m1.seg == 4 && m1.ramp == 5) && n < 200) begin
            tick(1, 1, 0);
            n++;
        end
        chk("reach_seg4", 32'(n < 200), 32'd1);
        tick(1, 1, 0);
        tick(0, 1, 1);
        chk_rgb("rst_seg4", 15, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick(1, 1, 0);
        chk("rst_nostep", 32'(bus1.update), 32'd0);
        tick(1, 1, 0);
        chk_rgb("rst_first", 15, 5, 0, 0, 1);
        for (int i = 0; i < 30; i++) tick(1, 1, 0);

        chk("sb1_left", 32'(q1.size()), 32'd0);
        chk("sb2_left", 32'(q2.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/hue_sequencer.md
HUE_SEQUENCER -- requirements
Module: hue_sequencer

Interface
REQ-001 SHALL have parameter PWM_INTERVAL, default 1200: PWM period in clk cycles; DUTY_MAX = PWM_INTERVAL-1.
REQ-002 SHALL have parameter STEP_CYCLES, default 12000: clk cycles per ramp step (1 ms at 12 MHz); legal range >= 1.
REQ-003 SHALL have parameter DUTY_INC, default 12: duty increment per step; legal range 1..DUTY_MAX.
REQ-004 SHALL have port clk  input  1  the single system clock; every flop is rising-edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port en  input  1  high = sequencer advances; low = freeze.
REQ-007 SHALL have port restart  input  1  synchronous return to the start of the hue wheel.
REQ-008 SHALL have ports pwm_value_R, pwm_value_G, pwm_value_B  output  $clog2(PWM_INTERVAL) each  registered duty values for the downstream PWM stages.
REQ-009 SHALL have port segment  output  3  current hue segment, 0..5.
REQ-010 SHALL have port update  output  1  one-cycle strobe, high in the first cycle new duty values are visible.

Function
REQ-011 SHALL run a step timer counting 0..STEP_CYCLES-1 while en=1; a step event occurs in the cycle the timer equals STEP_CYCLES-1 and en=1, and the timer then wraps to 0.
REQ-012 SHALL hold the timer, ramp, segment and all outputs unchanged while en=0; update SHALL be 0.
REQ-013 SHALL keep a ramp register 0..DUTY_MAX; on a step, ramp<DUTY_MAX -> ramp = min(ramp+DUTY_INC, DUTY_MAX), with the sum computed one bit wider so no wrap occurs.
REQ-014 SHALL, on a step with ramp==DUTY_MAX, set ramp=0 and advance segment: 0->1->2->3->4->5->0.
REQ-015 SHALL drive the duty values (M=DUTY_MAX, r=ramp) per segment: 0: R=M, G=r, B=0; 1: R=M-r, G=M, B=0; 2: R=0, G=M, B=r; 3: R=0, G=M-r, B=M; 4: R=r, G=0, B=M; 5: R=M, G=0, B=M-r.
REQ-016 SHALL register the duty and segment outputs so that they reflect the post-step ramp/segment one cycle after the step edge, with no combinational path from any input to any output.
REQ-017 SHALL assert update for exactly one cycle, coincident with the first cycle new values appear after each step or restart.
REQ-018 SHALL make a segment dwell ceil(DUTY_MAX/DUTY_INC)+1 steps; the first step of each segment repeats the previous endpoint value.
REQ-019 SHALL, when restart=1, clear timer, ramp and segment to 0 and load the outputs with the segment-0, ramp-0 values; update SHALL pulse in the next cycle regardless of en.
REQ-020 SHALL give restart priority over a coincident step event, and rst_n priority over restart.
REQ-021 SHALL keep every duty value within 0..DUTY_MAX at all times.

Reset
REQ-022 SHALL, while rst_n=0 at a clk edge, set timer=0, ramp=0, segment=0, pwm_value_R=DUTY_MAX, pwm_value_G=0, pwm_value_B=0 and update=0.
REQ-023 SHALL, when reset is asserted mid-segment, discard all progress; after release, the sequence restarts from segment 0 with a full STEP_CYCLES before the first step.

Verification (PWM_INTERVAL=16, STEP_CYCLES=4, DUTY_INC=5, so DUTY_MAX=15)
REQ-024 SHALL cover: reset, then en=1 -> R/G/B=15/0/0 and segment=0; G steps 5, 10, 15 every 4 cycles with a one-cycle update on each; the 4th step gives segment=1 with R=15.
REQ-025 SHALL cover: en=1 for 96 cycles after reset -> all 24 steps traverse segments 0..5 and return to segment 0 with R/G/B=15/0/0.
REQ-026 SHALL cover: en dropped for 10 cycles mid-ramp at G=10 -> outputs and timer frozen with no update; after resume, the next step arrives after the remaining timer count.
REQ-027 SHALL cover: restart asserted on a step cycle in segment 3 -> next cycle R/G/B=15/0/0, segment=0 and update=1, with the step discarded.
REQ-028 SHALL cover: DUTY_INC=4 -> ramp sequence 0, 4, 8, 12, 15 (clamped) then advance, with no value above 15.
REQ-029 SHALL cover: rst_n low for one cycle in segment 4 -> outputs return to the reset values on that edge, and restart asserted together with rst_n has no additional effect.
